// File: rtl/pixel_write_sink.sv
// pixel_write_sink: receiving end of the pixel-plot stream.
//   Drops off-screen pixels, buffers the rest in a DEPTH-entry FIFO and drains them to a
//   single-port framebuffer write port that may stall (fb_busy).
// Optional build macro: PIXEL_SINK_COALESCE_EN -- a new pixel hitting the same (x, y) as the
//   FIFO tail overwrites the tail's colour instead of pushing.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   in_x/in_y/in_colour  pixel column/row/RGB; in_plot requests a write on this edge
//   in_ready             FIFO not full
//   fb_addr/fb_data      linear address (y*H_RES + x) and colour of the current write
//   fb_wren, fb_busy     write strobe; write completes when fb_wren=1 and fb_busy=0
//   clip_count           saturating count of dropped off-screen pixels
//   overflow             sticky, an in-range pixel arrived while the FIFO was full
//   fifo_level           current FIFO occupancy
module pixel_write_sink #(
   parameter int unsigned H_RES  = 160,
   parameter int unsigned V_RES  = 120,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 15
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [7:0]               in_x,
   input  logic [7:0]               in_y,
   input  logic [2:0]               in_colour,
   input  logic                     in_plot,
   output logic                     in_ready,
   output logic [ADDR_W-1:0]        fb_addr,
   output logic [2:0]               fb_data,
   output logic                     fb_wren,
   input  logic                     fb_busy,
   output logic [15:0]              clip_count,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [8:0] HLim = 9'(H_RES);
   localparam logic [8:0] VLim = 9'(V_RES);

   typedef enum logic [0:0] {StIdle, StWrite} state_e;

   state_e            state_q, state_d;
   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic [7:0]        mem_x_q [DEPTH];
   logic [7:0]        mem_y_q [DEPTH];
   logic [2:0]        mem_c_q [DEPTH];
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        data_q;
   logic [15:0]       clip_q;
   logic              ovf_q;

   logic [AW-1:0] widx, ridx;
   logic          empty, full, in_range, clip, push, pop, coalesce, ovf_set;

   // Shift-add form for the default width avoids a multiplier.
   function automatic logic [ADDR_W-1:0] lin_addr(input logic [7:0] x, input logic [7:0] y);
      logic [ADDR_W-1:0] xe, ye;
      xe = ADDR_W'(x);
      ye = ADDR_W'(y);
      if (H_RES == 160) return (ye << 7) + (ye << 5) + xe;
      else              return (ye * ADDR_W'(H_RES)) + xe;
   endfunction

   assign widx  = wr_ptr_q[AW-1:0];
   assign ridx  = rd_ptr_q[AW-1:0];
   assign empty = (wr_ptr_q == rd_ptr_q);
   // Extra pointer bit separates full from empty when the indices match.
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (widx == ridx);

   assign in_range = ({1'b0, in_x} < HLim) && ({1'b0, in_y} < VLim);
   assign clip     = in_plot && !in_range;

`ifdef PIXEL_SINK_COALESCE_EN
   logic [AW-1:0] tail_idx;
   assign tail_idx = widx - AW'(1);
   // The tail is the most recent push whenever the FIFO is non-empty; it must not be
   // leaving on this edge (only possible when it is also the head).
   assign coalesce = in_plot && in_range && !empty &&
                     (mem_x_q[tail_idx] == in_x) && (mem_y_q[tail_idx] == in_y) &&
                     !(pop && (fifo_level == (AW+1)'(1)));
`else
   assign coalesce = 1'b0;
`endif

   assign push    = in_plot && in_range && !coalesce && !full;
   assign ovf_set = in_plot && in_range && !coalesce && full;

   // Drain FSM next state and pop decision.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (!fb_busy) begin
               if (!empty) pop = 1'b1;
               else        state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         clip_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            addr_q   <= lin_addr(mem_x_q[ridx], mem_y_q[ridx]);
            data_q   <= mem_c_q[ridx];
         end
         if (clip && (clip_q != 16'hFFFF)) clip_q <= clip_q + 16'd1;
         if (ovf_set) ovf_q <= 1'b1;
      end
   end

   // Storage needs no reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_x_q[widx] <= in_x;
         mem_y_q[widx] <= in_y;
         mem_c_q[widx] <= in_colour;
      end
`ifdef PIXEL_SINK_COALESCE_EN
      if (coalesce) mem_c_q[tail_idx] <= in_colour;
`endif
   end

   assign in_ready   = !full;
   assign fb_addr    = addr_q;
   assign fb_data    = data_q;
   assign fb_wren    = (state_q == StWrite);
   assign clip_count = clip_q;
   assign overflow   = ovf_q;
   assign fifo_level = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Randomized bench for pixel_write_sink with a queue-based reference model.
module tb_pixel_write_sink;

   localparam int H = 160;
   localparam int V = 120;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  in_x, in_y;
   logic [2:0]  in_colour;
   logic        in_plot, in_ready;
   logic [14:0] fb_addr;
   logic [2:0]  fb_data;
   logic        fb_wren, fb_busy;
   logic [15:0] clip_count;
   logic        overflow;
   logic [4:0]  fifo_level;

   pixel_write_sink #(.H_RES(H), .V_RES(V), .DEPTH(DEPTH), .ADDR_W(15)) dut (
      .clk(clk), .resetn(resetn), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
      .in_plot(in_plot), .in_ready(in_ready), .fb_addr(fb_addr), .fb_data(fb_data),
      .fb_wren(fb_wren), .fb_busy(fb_busy), .clip_count(clip_count), .overflow(overflow),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {int x; int y; int c;} pix_t;

   // Reference model state: queued pixels, the pixel being written, status.
   pix_t q[$];
   pix_t slot;
   bit   slot_act;
   int   m_clip;
   bit   m_ovf;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      slot_act = 0;
      m_clip   = 0;
      m_ovf    = 0;
   endtask

   task automatic check_all();
      check_val("fb_wren", 32'(fb_wren), 32'(slot_act));
      if (slot_act) begin
         check_val("fb_addr", 32'(fb_addr), 32'(slot.y * H + slot.x));
         check_val("fb_data", 32'(fb_data), 32'(slot.c));
      end
      check_val("fifo_level", 32'(fifo_level), 32'(q.size()));
      check_val("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      check_val("overflow", 32'(overflow), 32'(m_ovf));
      check_val("clip_count", 32'(clip_count), 32'(m_clip));
   endtask

   // One clock edge of the specified behaviour, from pre-edge state and inputs.
   task automatic model_step(input bit p, input int x, input int y, input int c, input bit b);
      bit in_r, pop, coal, full;
      int sz;
      sz   = q.size();
      in_r = (x < H) && (y < V);
      full = (sz == DEPTH);
      pop  = (sz > 0) && (!slot_act || !b);
      coal = 0;
`ifdef PIXEL_SINK_COALESCE_EN
      if (p && in_r && sz > 0 && q[sz-1].x == x && q[sz-1].y == y && !(pop && sz == 1)) begin
         coal = 1;
         q[sz-1].c = c;
      end
`endif
      if (p && !in_r) begin
         if (m_clip < 65535) m_clip++;
      end else if (p && !coal && full) begin
         m_ovf = 1;
      end
      if (slot_act && !b) slot_act = 0;
      if (pop) begin
         slot     = q.pop_front();
         slot_act = 1;
      end
      if (p && in_r && !coal && !full) q.push_back('{x: x, y: y, c: c});
   endtask

   task automatic cycle(input bit p, input int x, input int y, input int c, input bit b);
      in_plot   = p;
      in_x      = 8'(x);
      in_y      = 8'(y);
      in_colour = 3'(c);
      fb_busy   = b;
      @(negedge clk);
      check_all();
      model_step(p, x, y, c, b);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit b);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, b);
   endtask

   initial begin
      resetn = 1'b0;
      in_plot = 0; in_x = 0; in_y = 0; in_colour = 0; fb_busy = 0;
      model_reset();
      #12;
      check_val("rst_fb_addr", 32'(fb_addr), 32'd0);
      check_val("rst_fb_data", 32'(fb_data), 32'd0);
      check_all();
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Single pixel: address 2*160+3 = 323.
      cycle(1, 3, 2, 7, 0);
      idle(4, 0);

      // Clipping.
      cycle(1, 160, 0, 5, 0);
      cycle(1, 0, 120, 5, 0);
      idle(3, 0);

      // Overflow with a stalled framebuffer, then drain.
      for (int i = 0; i < 18; i++) cycle(1, i, 10, i % 8, 1);
      idle(2, 1);
      idle(22, 0);

      // Stall on the far corner pixel.
      cycle(1, 159, 119, 2, 1);
      idle(5, 1);
      idle(3, 0);

      // Same-coordinate pair behind an occupied write slot.
      cycle(1, 0, 0, 1, 1);
      cycle(1, 5, 5, 7, 1);
      cycle(1, 5, 5, 0, 1);
      idle(2, 1);
      idle(5, 0);

      // Reset in the middle of a stalled drain.
      for (int i = 0; i < 8; i++) cycle(1, 20 + i, 30, i, 1);
      idle(2, 1);
      in_plot = 0;
      #1 resetn = 1'b0;
      #1;
      model_reset();
      check_val("midrst_wren", 32'(fb_wren), 32'd0);
      check_val("midrst_level", 32'(fifo_level), 32'd0);
      check_val("midrst_ovf", 32'(overflow), 32'd0);
      check_val("midrst_clip", 32'(clip_count), 32'd0);
      #1 resetn = 1'b1;
      idle(5, 0);

      // Randomized phases with increasing stall probability.
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < 250; i++) begin
            int r, x, y;
            bit p, b;
            r = $urandom_range(0, 99);
            p = ($urandom_range(0, 99) < 70);
            if (r < 10) begin
               x = $urandom_range(160, 255); y = $urandom_range(0, 255);
            end else if (r < 15) begin
               x = $urandom_range(0, 159);   y = $urandom_range(120, 255);
            end else if (r < 55) begin
               x = $urandom_range(0, 2);     y = $urandom_range(0, 1);
            end else begin
               x = $urandom_range(0, 159);   y = $urandom_range(0, 119);
            end
            b = ($urandom_range(0, 99) < ph * 30);
            cycle(p, x, y, $urandom_range(0, 7), b);
         end
      end
      idle(25, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
